// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle RV32I operations plus an iterative shift-add multiply.
// Valid/ready handshakes on both sides let the pipeline stall around the multi-cycle path.
module alu_exec_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       ALUControl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal
);

    localparam int SHW  = $clog2(WIDTH);
    localparam int CNTW = $clog2(WIDTH + 1);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_SLT = 4'b0101;
    localparam logic [3:0] OP_SLL = 4'b0110;
    localparam logic [3:0] OP_SRL = 4'b0111;
    localparam logic [3:0] OP_SRA = 4'b1000;
    localparam logic [3:0] OP_MUL = 4'b1001;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

    state_t            state;
    logic [WIDTH-1:0]  mcand;
    logic [WIDTH-1:0]  mplier;
    logic [WIDTH-1:0]  acc;
    logic [WIDTH-1:0]  acc_nxt;
    logic [WIDTH-1:0]  alu_res;
    logic [CNTW-1:0]   cnt;
    logic              op_mul;
    logic              op_rsvd;
    logic              accept;

    // Reserved codes and the mul code fall through to zero here; mul is handled by the FSM.
    function automatic logic [WIDTH-1:0] alu_op(input logic [3:0]       op,
                                                input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y);
        logic signed [WIDTH-1:0] xs;
        logic signed [WIDTH-1:0] ys;
        logic [SHW-1:0]          sh;
        logic [WIDTH-1:0]        r;
        xs = x;
        ys = y;
        sh = y[SHW-1:0];
        case (op)
            OP_ADD:  r = x + y;
            OP_SUB:  r = x - y;
            OP_AND:  r = x & y;
            OP_OR:   r = x | y;
            OP_XOR:  r = x ^ y;
            OP_SLT:  r = {{(WIDTH-1){1'b0}}, (xs < ys)};
            OP_SLL:  r = x << sh;
            OP_SRL:  r = x >> sh;
            OP_SRA:  r = xs >>> sh;
            default: r = '0;
        endcase
        return r;
    endfunction

    always_comb begin
        op_mul   = (ALUControl == OP_MUL);
        op_rsvd  = (ALUControl > OP_MUL);
        in_ready = (state == IDLE) && (!out_valid || out_ready);
        accept   = in_valid && in_ready;
        alu_res  = alu_op(ALUControl, a, b);
        acc_nxt  = mplier[0] ? (acc + mcand) : acc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            illegal   <= 1'b0;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (op_mul) begin
                            // Accept implies the output slot is free or draining this edge.
                            mcand     <= a;
                            mplier    <= b;
                            acc       <= '0;
                            cnt       <= '0;
                            out_valid <= 1'b0;
                            state     <= MUL;
                        end else begin
                            result    <= alu_res;
                            zero      <= (alu_res == '0);
                            illegal   <= op_rsvd;
                            out_valid <= 1'b1;
                        end
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                MUL: begin
                    acc    <= acc_nxt;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CNTW'(1);
                    if (cnt == CNTW'(WIDTH - 1)) begin
                        result    <= acc_nxt;
                        zero      <= (acc_nxt == '0);
                        illegal   <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed scenarios plus a randomized
// transaction-level scoreboard against an arithmetic reference model.
module tb_alu_exec_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [3:0]   op = 4'd0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] result;
    logic         zero;
    logic         illegal;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    alu_exec_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ALUControl(op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .illegal   (illegal)
    );

    // Reference: {illegal, zero, result} from plain arithmetic on the operation code.
    function automatic logic [W+1:0] model(input logic [3:0] c,
                                           input logic [W-1:0] x,
                                           input logic [W-1:0] y);
        logic [63:0]  p;
        logic [W-1:0] r;
        logic         ill;
        int           sh;
        sh  = int'(y[4:0]);
        ill = 1'b0;
        p   = 64'(x) * 64'(y);
        case (c)
            4'd0: r = x + y;
            4'd1: r = x - y;
            4'd2: r = x & y;
            4'd3: r = x | y;
            4'd4: r = x ^ y;
            4'd5: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            4'd6: r = x << sh;
            4'd7: r = x >> sh;
            4'd8: r = $signed(x) >>> sh;
            4'd9: r = p[31:0];
            default: begin
                r   = '0;
                ill = 1'b1;
            end
        endcase
        return {ill, (r == '0), r};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b1; op = 4'd0; a = 32'd3; b = 32'd4; out_ready = 1'b1;
        repeat (3) step();
        n_tests++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
        n_tests++;
        if (result !== 32'd0) begin n_fail++; $display("FAIL reset_result: got %h expected 0", result); end
        n_tests++;
        if (zero !== 1'b0 || illegal !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got zero=%0b illegal=%0b expected 0 0", zero, illegal); end
        in_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        n_tests++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %0b expected 1", in_ready); end
        step();
    endtask

    task automatic test_sub_zero();
        out_ready = 1'b1; op = 4'd1; a = 32'd5; b = 32'd5; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        n_tests++;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL sub_out_valid: got %0b expected 1", out_valid); end
        n_tests++;
        if (result !== 32'd0 || zero !== 1'b1 || illegal !== 1'b0) begin
            n_fail++; $display("FAIL sub_zero: got result=%h zero=%0b illegal=%0b expected 0 1 0", result, zero, illegal);
        end
        step();
        n_tests++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL sub_drain: got out_valid=%0b expected 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1; op = 4'd0; a = 32'hFFFF_FFFF; b = 32'd1; in_valid = 1'b1;
        step();
        n_tests++;
        if (out_valid !== 1'b1 || result !== 32'd0 || zero !== 1'b1) begin
            n_fail++; $display("FAIL b2b_first: got valid=%0b result=%h zero=%0b expected 1 0 1", out_valid, result, zero);
        end
        n_tests++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready: got %0b expected 1", in_ready); end
        a = 32'd2; b = 32'd3;
        step();
        in_valid = 1'b0;
        n_tests++;
        if (out_valid !== 1'b1 || result !== 32'd5 || zero !== 1'b0) begin
            n_fail++; $display("FAIL b2b_second: got valid=%0b result=%h zero=%0b expected 1 5 0", out_valid, result, zero);
        end
        step();
        n_tests++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: got out_valid=%0b expected 0", out_valid); end
    endtask

    task automatic test_compare_shift();
        logic [3:0]   ops [3];
        logic [W-1:0] as  [3];
        logic [W-1:0] bs  [3];
        logic [W-1:0] exp [3];
        ops = '{4'd5, 4'd8, 4'd7};
        as  = '{32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000};
        bs  = '{32'd1, 32'h24, 32'h24};
        exp = '{32'd1, 32'hF800_0000, 32'h0800_0000};
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            op = ops[i]; a = as[i]; b = bs[i]; in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            n_tests++;
            if (out_valid !== 1'b1 || result !== exp[i]) begin
                n_fail++; $display("FAIL cmp_shift_%0d: got valid=%0b result=%h expected 1 %h", i, out_valid, result, exp[i]);
            end
            step();
        end
    endtask

    task automatic test_mul();
        logic [W-1:0] as  [2];
        logic [W-1:0] bs  [2];
        logic [W-1:0] exp [2];
        int cycles;
        int low_ready;
        as  = '{32'd7, 32'hFFFF_FFFF};
        bs  = '{32'd6, 32'd2};
        exp = '{32'd42, 32'hFFFF_FFFE};
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            op = 4'd9; a = as[i]; b = bs[i]; in_valid = 1'b1;
            step();
            // A competing add is held on the inputs for the whole multiply.
            op = 4'd0; a = 32'd100; b = 32'd200;
            cycles = 0; low_ready = 0;
            while (out_valid !== 1'b1 && cycles < 100) begin
                if (in_ready === 1'b0) low_ready++;
                step();
                cycles++;
            end
            in_valid = 1'b0;
            n_tests++;
            if (cycles != 32) begin n_fail++; $display("FAIL mul_latency_%0d: got %0d expected 32", i, cycles); end
            n_tests++;
            if (low_ready != 32) begin n_fail++; $display("FAIL mul_in_ready_low_%0d: got %0d cycles expected 32", i, low_ready); end
            n_tests++;
            if (result !== exp[i] || illegal !== 1'b0 || zero !== 1'b0) begin
                n_fail++; $display("FAIL mul_result_%0d: got %h zero=%0b illegal=%0b expected %h 0 0", i, result, zero, illegal, exp[i]);
            end
            step();
            n_tests++;
            if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mul_no_extra_%0d: got out_valid=%0b expected 0", i, out_valid); end
        end
    endtask

    task automatic test_backpressure();
        op = 4'd0; a = 32'd3; b = 32'd4; in_valid = 1'b1; out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_tests++;
            if (out_valid !== 1'b1 || result !== 32'd7 || in_ready !== 1'b0) begin
                n_fail++; $display("FAIL bp_hold_%0d: got valid=%0b result=%h in_ready=%0b expected 1 7 0", i, out_valid, result, in_ready);
            end
            step();
        end
        out_ready = 1'b1;
        #1;
        n_tests++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_in_ready: got %0b expected 1", in_ready); end
        step();
        n_tests++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release: got out_valid=%0b expected 0", out_valid); end
    endtask

    task automatic test_reserved();
        out_ready = 1'b1;
        for (int c = 10; c < 16; c++) begin
            op = 4'(c); a = $urandom | 32'd1; b = $urandom; in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            n_tests++;
            if (out_valid !== 1'b1 || result !== 32'd0 || zero !== 1'b1 || illegal !== 1'b1) begin
                n_fail++; $display("FAIL reserved_%0d: got valid=%0b result=%h zero=%0b illegal=%0b expected 1 0 1 1", c, out_valid, result, zero, illegal);
            end
            step();
        end
    endtask

    task automatic test_abort();
        bit seen;
        out_ready = 1'b1; op = 4'd9; a = 32'd123; b = 32'd456; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (10) step();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL abort_state: got out_valid=%0b in_ready=%0b expected 0 1", out_valid, in_ready);
        end
        op = 4'd0; a = 32'd1; b = 32'd1; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        n_tests++;
        if (out_valid !== 1'b1 || result !== 32'd2) begin
            n_fail++; $display("FAIL abort_add: got valid=%0b result=%h expected 1 2", out_valid, result);
        end
        step();
        seen = 1'b0;
        repeat (40) begin
            if (out_valid === 1'b1) seen = 1'b1;
            step();
        end
        n_tests++;
        if (seen) begin n_fail++; $display("FAIL abort_no_result: got out_valid after abort expected none"); end
    endtask

    task automatic test_random();
        logic [W+1:0] exp_q[$];
        logic [W+1:0] e;
        logic [W+1:0] got;
        int issued;
        int cyc;
        int r;
        bit acc;
        bit cons;
        issued = 0;
        cyc = 0;
        while (cyc < 20000 && (issued < 300 || exp_q.size() > 0)) begin
            if (issued < 300 && $urandom_range(0, 3) != 0) begin
                r  = $urandom_range(0, 19);
                op = (r < 16) ? 4'(r) : 4'd9;
                a  = $urandom;
                b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            acc  = in_valid && in_ready;
            cons = out_valid && out_ready;
            if (cons) begin
                n_tests++;
                got = {illegal, zero, result};
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL rand_unexpected: got output %h expected none", got);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin
                        n_fail++; $display("FAIL rand_result: got {ill,zero,res}=%h expected %h", got, e);
                    end
                end
            end
            if (acc) begin
                exp_q.push_back(model(op, a, b));
                issued++;
            end
            step();
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        n_tests++;
        if (exp_q.size() != 0 || issued != 300) begin
            n_fail++; $display("FAIL rand_drain: got %0d pending, %0d issued expected 0 pending, 300 issued", exp_q.size(), issued);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_sub_zero();
        test_back_to_back();
        test_compare_shift();
        test_mul();
        test_backpressure();
        test_reserved();
        test_abort();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
